// File: rtl/ysyx_22050039_ctrl_pkg.sv
// rtl/ysyx_22050039_ctrl_pkg.sv - shared state encoding and halt codes for the stage controller
package ysyx_22050039_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_EBREAK  = 2'd1;
    localparam logic [1:0] HALT_INVALID = 2'd2;
    localparam logic [1:0] HALT_WDOG    = 2'd3;

endpackage

// File: rtl/ysyx_22050039_wait_timer.sv
// rtl/ysyx_22050039_wait_timer.sv - watchdog counter for EXEC/MEM wait states
module ysyx_22050039_wait_timer #(
    parameter int WAIT_MAX = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int TW = $clog2(WAIT_MAX);

    logic [TW-1:0] r_cnt;

    // The cycle whose count is WAIT_MAX-1 is the WAIT_MAX-th wait cycle.
    assign o_expired = i_enable && (r_cnt == TW'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22050039_stage_ctrl.sv
// rtl/ysyx_22050039_stage_ctrl.sv - multi-cycle IFU/IDU/EXU/LSU/WB sequencer; YSYX_22050039_PERF_CNT_EN builds perf counters
module ysyx_22050039_stage_ctrl
    import ysyx_22050039_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 256,
    parameter int CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_valid,
    output logic             ifu_req,
    output logic             inst_latch,
    input  logic             dec_wreg,
    input  logic             dec_mem,
    input  logic             dec_multi,
    input  logic             dec_ebreak,
    input  logic             dec_invalid,
    output logic             exu_start,
    input  logic             exu_done,
    output logic             lsu_req,
    input  logic             lsu_done,
    output logic             reg_wen,
    output logic             pc_wen,
    output logic             halted,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_e     r_state;
    logic [1:0] r_halt_code;
    logic       r_exec_first;

    logic w_in_exec;
    logic w_in_mem;
    logic w_exec_ok;
    logic w_tmr_clear;
    logic w_expired;

    assign w_in_exec = (r_state == S_EXEC);
    assign w_in_mem  = (r_state == S_MEM);
    assign w_exec_ok = !dec_multi || exu_done;
    // Restart the count on every entry to a wait state, including EXEC -> MEM.
    assign w_tmr_clear = !(w_in_exec || w_in_mem) || (w_in_exec && w_exec_ok);

    ysyx_22050039_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_in_exec || w_in_mem),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_halt_code  <= HALT_NONE;
            r_exec_first <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: if (ifu_valid) r_state <= S_DECODE;
                S_DECODE: begin
                    if (dec_invalid) begin
                        r_state     <= S_HALT;
                        r_halt_code <= HALT_INVALID;
                    end else if (dec_ebreak) begin
                        r_state     <= S_HALT;
                        r_halt_code <= HALT_EBREAK;
                    end else begin
                        r_state      <= S_EXEC;
                        r_exec_first <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_exec_first <= 1'b0;
                    if (w_exec_ok) begin
                        r_state <= dec_mem ? S_MEM : S_WB;
                    end else if (w_expired) begin
                        r_state     <= S_HALT;
                        r_halt_code <= HALT_WDOG;
                    end
                end
                S_MEM: begin
                    if (lsu_done) begin
                        r_state <= S_WB;
                    end else if (w_expired) begin
                        r_state     <= S_HALT;
                        r_halt_code <= HALT_WDOG;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign ifu_req    = (r_state == S_FETCH);
    assign inst_latch = (r_state == S_FETCH) && ifu_valid;
    assign exu_start  = w_in_exec && r_exec_first && dec_multi;
    assign lsu_req    = w_in_mem;
    // A reset landing on the WB cycle must not commit the aborted instruction.
    assign pc_wen     = (r_state == S_WB) && !rst;
    assign reg_wen    = (r_state == S_WB) && dec_wreg && !rst;
    assign halted     = (r_state == S_HALT);
    assign halt_code  = r_halt_code;

`ifdef YSYX_22050039_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != S_HALT) r_cycle_cnt   <= r_cycle_cnt + 1'b1;
            if (r_state == S_WB)   r_instret_cnt <= r_instret_cnt + 1'b1;
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
